// File: rtl/ram_pkg.sv
// ram_pkg: shared state type and BitBlaster default geometry for the parametrised RAM
package ram_pkg;
  typedef enum logic {RAM_IDLE, RAM_CLEAR} ram_state_t;
  localparam int BB_DATA_WIDTH = 10;
  localparam int BB_ADDR_WIDTH = 10;
endpackage

// File: rtl/ram_storage.sv
// ram_storage: unreset word array with a posedge write port and a posedge registered read port
module ram_storage #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 2**ADDR_WIDTH
)(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[IW-1:0]];
  end
endmodule

// File: rtl/ram_param_sync.sv
// ram_param_sync: single-port sync RAM with clear sweep, registered read, readback and range check
module ram_param_sync
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = BB_DATA_WIDTH,
  parameter int                    ADDR_WIDTH     = BB_ADDR_WIDTH,
  parameter int                    DEPTH          = 2**ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    WRITE_READBACK = 1'b0
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  addr_error,
  output logic                  busy
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);
  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d, waddr;
  logic [DATA_WIDTH-1:0] rd_alt_q, rd_alt_d, wdata, mem_rdata;
  logic                  rd_valid_q, rd_valid_d, rd_sel_q, rd_sel_d, addr_error_q, addr_error_d;
  logic                  in_range, acc, sweep, we, re;
  assign ready      = state_q == RAM_IDLE && !clear_req;
  assign busy       = state_q == RAM_CLEAR;
  assign rd_valid   = rd_valid_q;
  assign addr_error = addr_error_q;
  assign rd_data    = rd_sel_q ? mem_rdata : rd_alt_q;
  always_comb begin
    in_range     = {1'b0, req_address} < DEPTH_W;
    acc          = req_valid && ready && !reset;
    sweep        = state_q == RAM_CLEAR && !reset;
    we           = sweep || (acc && req_write && in_range);
    re           = acc && !req_write && in_range;
    waddr        = sweep ? clr_ptr_q : req_address;
    wdata        = sweep ? CLEAR_VALUE : req_data;
    state_d      = state_q == RAM_CLEAR ? ({1'b0, clr_ptr_q} == LAST_W ? RAM_IDLE : RAM_CLEAR)
                                        : (clear_req ? RAM_CLEAR : RAM_IDLE);
    clr_ptr_d    = state_q == RAM_CLEAR ? clr_ptr_q + ADDR_WIDTH'(1) : '0;
    rd_valid_d   = acc && (!req_write || (WRITE_READBACK && in_range));
    rd_sel_d     = rd_valid_d ? re : rd_sel_q;
    rd_alt_d     = (acc && !req_write && !in_range) ? '0
                 : (acc && req_write && in_range && WRITE_READBACK) ? req_data : rd_alt_q;
    addr_error_d = acc && !in_range;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RAM_CLEAR;
      clr_ptr_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
      rd_alt_q     <= '0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      rd_valid_q   <= rd_valid_d;
      rd_sel_q     <= rd_sel_d;
      rd_alt_q     <= rd_alt_d;
      addr_error_q <= addr_error_d;
    end
  end
  ram_storage #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (req_address),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_ram_param_sync.sv
// tb_ram_param_sync: scoreboard bench for two RAM configurations (1024x10 readback, 16-deep narrow address)
module tb_ram_param_sync;
  typedef struct packed {logic v; logic [9:0] d; logic e;} exp_t;
  logic       clk = 1'b0;
  logic       reset [2];
  logic       clear_req [2];
  logic       req_valid [2];
  logic       req_write [2];
  logic [9:0] req_address [2];
  logic [9:0] req_data [2];
  logic       ready [2];
  logic       rd_valid [2];
  logic       addr_error [2];
  logic       busy [2];
  logic [9:0] rd_data [2];
  exp_t       q0 [$];
  exp_t       q1 [$];
  int         checks = 0;
  int         fails = 0;
  always #5 clk = ~clk;
  ram_param_sync #(.DATA_WIDTH(10), .ADDR_WIDTH(10), .DEPTH(1024), .CLEAR_VALUE(10'h155), .WRITE_READBACK(1'b1)) u_a (
    .clk(clk), .reset(reset[0]), .clear_req(clear_req[0]), .req_valid(req_valid[0]),
    .req_write(req_write[0]), .req_address(req_address[0]), .req_data(req_data[0]),
    .ready(ready[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .addr_error(addr_error[0]), .busy(busy[0])
  );
  ram_param_sync #(.DATA_WIDTH(10), .ADDR_WIDTH(5), .DEPTH(16), .CLEAR_VALUE(10'h0F0), .WRITE_READBACK(1'b0)) u_b (
    .clk(clk), .reset(reset[1]), .clear_req(clear_req[1]), .req_valid(req_valid[1]),
    .req_write(req_write[1]), .req_address(req_address[1][4:0]), .req_data(req_data[1]),
    .ready(ready[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .addr_error(addr_error[1]), .busy(busy[1])
  );
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_valid[k] || addr_error[k]) begin
        exp_t e;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output inst%0d: rd_valid=%b addr_error=%b rd_data=0x%0h, expected no output",
                   k, rd_valid[k], addr_error[k], rd_data[k]);
        end else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check($sformatf("rd_valid inst%0d", k), int'(rd_valid[k]), int'(e.v));
          check($sformatf("addr_error inst%0d", k), int'(addr_error[k]), int'(e.e));
          if (e.v) check($sformatf("rd_data inst%0d", k), int'(rd_data[k]), int'(e.d));
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic access(int k, bit wr, int addr, int data, bit out, bit ev, int ed, bit ee);
    exp_t e;
    check($sformatf("ready inst%0d before access", k), int'(ready[k]), 1);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_address[k] = 10'(addr);
    req_data[k] = 10'(data);
    e.v = ev;
    e.d = 10'(ed);
    e.e = ee;
    if (out && k == 0) q0.push_back(e);
    if (out && k == 1) q1.push_back(e);
    cyc();
    req_valid[k] = 1'b0;
  endtask
  task automatic count_sweep(int k, output int n);
    n = 0;
    for (int i = 0; i < 3000 && !ready[k]; i++) begin
      cyc();
      n++;
    end
  endtask
  initial begin
    int n0, n1;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      clear_req[k] = 1'b0;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_address[k] = '0;
      req_data[k] = '0;
    end
    cyc();
    cyc();
    check("reset ready", int'(ready[0]), 0);
    check("reset busy", int'(busy[0]), 1);
    check("reset rd_valid", int'(rd_valid[0]), 0);
    check("reset rd_data", int'(rd_data[0]), 0);
    check("reset addr_error", int'(addr_error[0]), 0);
    check("reset busy b", int'(busy[1]), 1);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int i = 1; i <= 3000 && (n0 == 0 || n1 == 0); i++) begin
      cyc();
      if (ready[0] && n0 == 0) n0 = i;
      if (ready[1] && n1 == 0) n1 = i;
    end
    check("sweep edges a", n0, 1024);
    check("sweep edges b", n1, 16);
    check("busy after sweep", int'(busy[0]), 0);
    access(0, 0, 0, 0, 1, 1, 'h155, 0);
    access(0, 0, 511, 0, 1, 1, 'h155, 0);
    access(0, 0, 1023, 0, 1, 1, 'h155, 0);
    access(0, 1, 7, 'h3FF, 1, 1, 'h3FF, 0);
    access(0, 0, 7, 0, 1, 1, 'h3FF, 0);
    access(0, 0, 7, 0, 1, 1, 'h3FF, 0);
    access(0, 1, 7, 'h001, 1, 1, 'h001, 0);
    access(0, 0, 7, 0, 1, 1, 'h001, 0);
    access(1, 1, 4, 'h123, 0, 0, 0, 0);
    access(1, 1, 15, 'h2F1, 0, 0, 0, 0);
    access(1, 1, 20, 'h2AA, 1, 0, 0, 1);
    access(1, 0, 20, 0, 1, 1, 0, 1);
    access(1, 0, 4, 0, 1, 1, 'h123, 0);
    access(1, 0, 31, 0, 1, 1, 0, 1);
    access(1, 0, 15, 0, 1, 1, 'h2F1, 0);
    access(1, 1, 3, 'h055, 0, 0, 0, 0);
    clear_req[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_address[1] = 10'd3;
    req_data[1] = 10'h3FF;
    #1;
    check("ready with clear_req", int'(ready[1]), 0);
    cyc();
    clear_req[1] = 1'b0;
    req_valid[1] = 1'b0;
    check("busy after clear_req", int'(busy[1]), 1);
    count_sweep(1, n1);
    check("clear_req sweep edges", n1, 16);
    access(1, 0, 3, 0, 1, 1, 'h0F0, 0);
    access(1, 0, 4, 0, 1, 1, 'h0F0, 0);
    access(0, 1, 800, 'h02A, 1, 1, 'h02A, 0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_address[0] = 10'd7;
    reset[0] = 1'b1;
    cyc();
    reset[0] = 1'b0;
    for (int i = 0; i < 500; i++) cyc();
    check("ready mid sweep", int'(ready[0]), 0);
    reset[0] = 1'b1;
    cyc();
    reset[0] = 1'b0;
    req_valid[0] = 1'b0;
    count_sweep(0, n0);
    check("restart sweep edges", n0, 1024);
    access(0, 0, 800, 0, 1, 1, 'h155, 0);
    access(0, 0, 7, 0, 1, 1, 'h155, 0);
    cyc();
    cyc();
    cyc();
    check("scoreboard a drained", q0.size(), 0);
    check("scoreboard b drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
